// File: rtl/kmeans_route_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_route_pkg
// Brief    : Shared constants and helpers for the k-means route demux.
// Revision : 1.0 - initial release
// ============================================================================
package kmeans_route_pkg;

  // Default sample width and channel count of the k-means datapath.
  localparam int KM_DATA_W = 91;
  localparam int KM_N_CH   = 8;

  // Cluster indices are 1-based; 0 and anything above the channel count are invalid.
  function automatic logic idx_valid(input int unsigned idx, input int unsigned n);
    return (idx >= 1) && (idx <= n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/route_slot.sv
`default_nettype none
// ============================================================================
// Module   : route_slot
// Brief    : One-entry output register with valid/ready flow control and a
//            saturating hit counter for a single cluster channel.
// Revision : 1.0 - initial release
// ============================================================================
module route_slot #(
  parameter int DATA_W = 91,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              out_ready,
  input  logic              cnt_clear,
  output logic              free,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  hit_cnt
);

  // A slot draining this cycle may be refilled on the same edge.
  assign free = ~valid | out_ready;

  // Entry register: load has priority over drain; data is kept after drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

  // Saturating hit counter; a clear on the same edge as a hit leaves zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (cnt_clear) begin
      hit_cnt <= '0;
    end else if (load && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kmeans_route_demux.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_route_demux
// Brief    : Registered index demux routing a sample to one of N_CH cluster
//            channels (or all of them), with hit and drop statistics.
// Revision : 1.0 - initial release
// ============================================================================
module kmeans_route_demux
  import kmeans_route_pkg::*;
#(
  parameter  int DATA_W = KM_DATA_W,
  parameter  int N_CH   = KM_N_CH,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = $clog2(N_CH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [IDX_W-1:0]       in_index,
  input  logic                   in_bcast,
  output logic                   in_ready,
  output logic [N_CH-1:0]        out_valid,
  output logic [N_CH*DATA_W-1:0] out_data,
  input  logic [N_CH-1:0]        out_ready,
  input  logic                   cnt_clear,
  output logic [N_CH*CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  logic            idx_ok;
  logic [N_CH-1:0] uni_sel;
  logic [N_CH-1:0] slot_free;
  logic [N_CH-1:0] slot_load;
  logic            accept;
  logic            drop;

  assign idx_ok = idx_valid(32'(in_index), N_CH);

  // One-hot decode of the 1-based index; all zero when the index is invalid.
  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_sel
      assign uni_sel[c] = idx_ok && (in_index == IDX_W'(c + 1));
    end
  endgenerate

  // Ready never looks at in_valid; an invalid unicast is always swallowed.
  always_comb begin
    in_ready = 1'b1;
    if (in_bcast) begin
      in_ready = &slot_free;
    end else if (idx_ok) begin
      in_ready = |(uni_sel & slot_free);
    end
  end

  assign accept    = in_valid & in_ready;
  assign slot_load = accept ? (in_bcast ? {N_CH{1'b1}} : uni_sel) : {N_CH{1'b0}};
  assign drop      = accept & ~in_bcast & ~idx_ok;

  // Saturating drop counter; clear wins over a coincident drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (cnt_clear) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Per-channel slots, flattened onto the output buses.
  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_slot
      route_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (slot_load[c]),
        .din       (in_data),
        .out_ready (out_ready[c]),
        .cnt_clear (cnt_clear),
        .free      (slot_free[c]),
        .valid     (out_valid[c]),
        .data      (out_data[c*DATA_W +: DATA_W]),
        .hit_cnt   (hit_cnt[c*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kmeans_route_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_kmeans_route_demux
// Brief    : Self-checking bench for kmeans_route_demux (8 channels, 4-bit
//            counters so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_kmeans_route_demux;

  localparam int DATA_W = 91;
  localparam int N_CH   = 8;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = $clog2(N_CH + 1);
  localparam int unsigned CMAX = (1 << CNT_W) - 1;
  localparam logic [N_CH-1:0] ALL = {N_CH{1'b1}};

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic [IDX_W-1:0]       in_index;
  logic                   in_bcast;
  logic                   in_ready;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [N_CH-1:0]        out_ready;
  logic                   cnt_clear;
  logic [N_CH*CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]       drop_cnt;

  always #5 clk = ~clk;

  kmeans_route_demux #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_index  (in_index),
    .in_bcast  (in_bcast),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cnt_clear (cnt_clear),
    .hit_cnt   (hit_cnt),
    .drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: per-channel expected samples plus modelled occupancy/counters.
  logic [DATA_W-1:0] sb [N_CH][$];
  logic [N_CH-1:0]   mv;
  int unsigned       mhit [N_CH];
  int unsigned       mdrop;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [IDX_W-1:0]  idx;
    logic              bc;
    logic [N_CH-1:0]   ordy;
    int                exp_ready;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      sb[c].delete();
      mhit[c] = 0;
    end
    mv    = '0;
    mdrop = 0;
  endtask

  // Drive one cycle of stimulus, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] idx,
                      input logic bc, input logic [N_CH-1:0] ordy, input logic clr,
                      input int exp_ready);
    logic [N_CH-1:0] fr;
    logic            ok;
    logic            er;
    in_valid  = v;
    in_data   = d;
    in_index  = idx;
    in_bcast  = bc;
    out_ready = ordy;
    cnt_clear = clr;
    @(negedge clk);
    fr = ~mv | ordy;
    ok = (int'(idx) >= 1) && (int'(idx) <= N_CH);
    er = bc ? (&fr) : (ok ? fr[int'(idx) - 1] : 1'b1);
    check("in_ready", in_ready, er);
    if (exp_ready >= 0) check("tbl_in_ready", in_ready, exp_ready[0]);
    check("drop_cnt", drop_cnt, mdrop);
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("out_valid[%0d]", c), out_valid[c], mv[c]);
      check($sformatf("hit_cnt[%0d]", c), hit_cnt[c*CNT_W +: CNT_W], mhit[c]);
      if (mv[c] && sb[c].size() > 0)
        check($sformatf("out_data[%0d]", c), out_data[c*DATA_W +: DATA_W], sb[c][0]);
      if (mv[c] && ordy[c]) begin
        if (sb[c].size() > 0) void'(sb[c].pop_front());
        mv[c] = 1'b0;
      end
    end
    if (v && er) begin
      if (bc) begin
        for (int c = 0; c < N_CH; c++) begin
          sb[c].push_back(d);
          mv[c] = 1'b1;
          if (mhit[c] < CMAX) mhit[c]++;
        end
      end else if (ok) begin
        sb[int'(idx) - 1].push_back(d);
        mv[int'(idx) - 1] = 1'b1;
        if (mhit[int'(idx) - 1] < CMAX) mhit[int'(idx) - 1]++;
      end else if (mdrop < CMAX) begin
        mdrop++;
      end
    end
    if (clr) begin
      for (int c = 0; c < N_CH; c++) mhit[c] = 0;
      mdrop = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] da, db, dc, dd;
    da = {27'h5A5A5A5, 64'hDEAD_BEEF_0000_0003};
    db = {27'h1234567, 64'hCAFE_F00D_0000_0333};
    dc = {27'h7FFFFFF, 64'h0123_4567_89AB_CDEF};
    dd = {27'h2AAAAAA, 64'hFEDC_BA98_7654_3210};

    // Reset: hold low for two edges, everything must read zero.
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_index = '0; in_bcast = 1'b0;
    out_ready = ALL; cnt_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, '0);
    check("rst out_data", out_data, '0);
    check("rst hit_cnt", hit_cnt, '0);
    check("rst drop_cnt", drop_cnt, '0);
    rst_n = 1'b1; in_index = 3;
    @(negedge clk);
    check("rst in_ready idx3", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Unicast burst on indices 1..8, then two drops, then idle to drain.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, DATA_W'(i + 1), IDX_W'(i + 1), 1'b0, ALL, 1};
    tbl[8]  = '{1'b1, DATA_W'(32'h99), IDX_W'(0), 1'b0, ALL, 1};
    tbl[9]  = '{1'b1, DATA_W'(32'h77), IDX_W'(9), 1'b0, ALL, 1};
    tbl[10] = '{1'b0, DATA_W'(0), IDX_W'(0), 1'b0, ALL, 1};
    tbl[11] = '{1'b0, DATA_W'(0), IDX_W'(2), 1'b0, ALL, 1};
    for (int i = 0; i < 12; i++)
      step(tbl[i].v, tbl[i].d, tbl[i].idx, tbl[i].bc, tbl[i].ordy, 1'b0, tbl[i].exp_ready);
    check("drop_cnt after drops", drop_cnt, 4'd2);
    check("out_valid after drops", out_valid, '0);
    for (int c = 0; c < N_CH; c++)
      check($sformatf("unicast hit_cnt[%0d]", c), hit_cnt[c*CNT_W +: CNT_W], 4'd1);

    // Clear counters, then backpressure on channel 2.
    step(1'b0, '0, '0, 1'b0, ALL, 1'b1, -1);
    step(1'b1, da, 3, 1'b0, 8'b1111_1011, 1'b0, 1);
    step(1'b1, db, 3, 1'b0, 8'b1111_1011, 1'b0, 0);
    step(1'b1, db, 3, 1'b0, 8'b1111_1011, 1'b0, 0);
    step(1'b1, db, 3, 1'b0, ALL, 1'b0, 1);
    step(1'b0, '0, 3, 1'b0, ALL, 1'b0, -1);
    check("bp hit_cnt[2]", hit_cnt[2*CNT_W +: CNT_W], 4'd2);

    // Broadcast stalls behind a full channel 5, then loads every channel.
    step(1'b1, dc, 6, 1'b0, 8'b1101_1111, 1'b0, 1);
    step(1'b1, dd, 0, 1'b1, 8'b1101_1111, 1'b0, 0);
    step(1'b1, dd, 0, 1'b1, 8'b1101_1111, 1'b0, 0);
    step(1'b1, dd, 0, 1'b1, ALL, 1'b0, 1);
    step(1'b0, '0, 0, 1'b0, ALL, 1'b0, -1);
    check("bcast out_data[7]", out_data[7*DATA_W +: DATA_W], dd);
    check("bcast drop_cnt", drop_cnt, '0);

    // Saturation on channel 0, then clear coinciding with a hit.
    for (int i = 0; i < 20; i++)
      step(1'b1, DATA_W'(i + 100), 1, 1'b0, ALL, 1'b0, 1);
    check("sat hit_cnt[0]", hit_cnt[CNT_W-1:0], 4'd15);
    step(1'b1, DATA_W'(555), 1, 1'b0, ALL, 1'b1, 1);
    check("clear wins hit_cnt[0]", hit_cnt[CNT_W-1:0], 4'd0);
    step(1'b0, '0, 0, 1'b0, ALL, 1'b0, -1);

    // Mid-operation reset discards a held sample.
    step(1'b1, da, 5, 1'b0, '0, 1'b0, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst out_valid", out_valid, '0);
    check("midrst out_data", out_data, '0);
    check("midrst hit_cnt", hit_cnt, '0);
    model_reset();
    rst_n = 1'b1;
    step(1'b1, db, 8, 1'b0, ALL, 1'b0, 1);
    step(1'b0, '0, 0, 1'b0, ALL, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kmeans_route_demux.md
# kmeans_route_demux

Parametrised, registered successor to the combinational index demux in the k-means datapath. It routes one sample, such as a point or a distance vector, to one of `N_CH` cluster channels selected by a 1-based index, or broadcasts it to all channels. Each channel has a one-entry output register with valid/ready flow control. Per-channel hit counters and a drop counter support debug and cluster-population statistics. It sits between the distance/argmin stage and the per-cluster accumulators.

## Interface
Parameters:
- `DATA_W`, default 91: sample width.
- `N_CH`, default 8: number of output channels (≥2).
- `CNT_W`, default 16: width of every statistics counter.
- `IDX_W`, derived as `$clog2(N_CH+1)`: index width; not overridable.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `in_valid`, in, 1: input sample valid.
- `in_data`, in, `DATA_W`: input sample.
- `in_index`, in, `IDX_W`: target channel (1..`N_CH`); 0 or >`N_CH` is invalid.
- `in_bcast`, in, 1: broadcast to all channels; overrides `in_index`.
- `in_ready`, out, 1: input accepted this cycle when `in_valid & in_ready`.
- `out_valid`, out, `N_CH`: bit c means channel c holds a sample.
- `out_data`, out, `N_CH*DATA_W`: channel c occupies `[c*DATA_W +: DATA_W]`.
- `out_ready`, in, `N_CH`: downstream accepts channel c.
- `cnt_clear`, in, 1: synchronous clear of all counters.
- `hit_cnt`, out, `N_CH*CNT_W`: channel c occupies `[c*CNT_W +: CNT_W]`.
- `drop_cnt`, out, `CNT_W`: number of accepted samples with an invalid index.

## Operation
- Channel c corresponds to index c+1.
- Slot c is free when `!out_valid[c] | out_ready[c]`; a slot drained this cycle can be refilled in the same cycle.
- `in_ready` is combinational:
  - Broadcast: AND of all slot-free terms.
  - Valid index: slot-free term of the target channel.
  - Invalid index, not broadcast: 1 (the sample is dropped).
- Accept, unicast: slot c loads `in_data` and sets `out_valid[c]`; `hit_cnt[c]` increments.
- Accept, broadcast: every slot loads and every `hit_cnt` increments. `drop_cnt` is unchanged.
- Accept, invalid index: no slot changes; `drop_cnt` increments.
- Drain: `out_valid[c] & out_ready[c]` with no reload clears `out_valid[c]`. `out_data` holds its last value and does not return to zero.
- Counters saturate at `2^CNT_W-1`.
- `cnt_clear` zeroes every counter. If `cnt_clear` coincides with an increment, the result is 0 (clear wins).
- `cnt_clear` does not affect slots or handshake.
- `out_data[c]` and `out_valid[c]` are stable while `out_valid[c] & !out_ready[c]`.
- `in_ready` may depend on `in_index`, `in_bcast` and `out_ready`, but never on `in_valid`.

## Timing
- Latency: a sample accepted at edge k appears on `out_valid`/`out_data` after edge k, i.e. 1 cycle.
- Throughput: 1 sample/cycle per channel when the downstream is always ready. A broadcast waits for the slowest channel.
- Counters update on the same edge as the accept. `hit_cnt` and `drop_cnt` are registered outputs.
- Reset (`rst_n`=0 at an edge):
  - `out_valid`=0, `out_data`=0, `hit_cnt`=0, `drop_cnt`=0.
  - `in_ready` is driven only by its combinational equation and is not forced during reset.
  - Mid-operation reset discards held samples without a downstream handshake.
- No internal state machine beyond the per-slot full/empty bit.

## Structure
- Package `kmeans_route_pkg`:
  - Helper function `idx_valid(idx, n)`.
  - Default-parameter constants `KM_DATA_W=91`, `KM_N_CH=8`.
- Sub-module `route_slot`, instantiated `N_CH` times via generate. It contains:
  - one-entry register, `load`/`out_ready` in, `free`/`valid`/`data` out;
  - its saturating `CNT_W` hit counter with clear.
- The top level holds decode, the `in_ready` reduction, the drop counter and flattening.

## Test plan
- **Reset:** after reset, hold `rst_n`=0 2 cycles → all outputs 0; `in_ready`=1 once `rst_n`=1 with `in_index`=3.
- **Unicast:** all `out_ready`=1; send index 1..8 with data 0x1..0x8 in consecutive cycles → each channel shows its value exactly 1 cycle later; `hit_cnt`=1 each; no bubbles.
- **Backpressure:** `out_ready[2]`=0; send index 3 twice → first sample held, `in_ready`=0 on the second. Raise `out_ready[2]` → drain and reload in the same cycle; `hit_cnt[2]`=2.
- **Broadcast:** `out_ready[5]`=0 with slot 5 full, `in_bcast`=1 → `in_ready`=0 until slot 5 drains. Then all 8 channels load the same data; every `hit_cnt` increments by 1.
- **Drops:** index 0 and index 9 (`IDX_W`=4) → accepted, no `out_valid`, `drop_cnt`=2.
- **Counters:** `CNT_W`=4, 20 hits on channel 0 → `hit_cnt[0]`=15 (saturated). Assert `cnt_clear` in the same cycle as a hit → 0.
